// File: rtl/bpf_isa_pkg.sv
// Classic-BPF ISA constants and decode helpers.
// Shared by the ALU issue controller, the jump unit and the datapath.
package bpf_isa_pkg;

  localparam logic [2:0] CLS_ALU  = 3'b100;
  localparam logic [2:0] CLS_MISC = 3'b111;
  localparam int         SRC_BIT  = 3;
  localparam logic [7:0] CODE_TAX = 8'h07;
  localparam logic [7:0] CODE_TXA = 8'h87;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_MUL = 4'h2,
    OP_DIV = 4'h3,
    OP_OR  = 4'h4,
    OP_AND = 4'h5,
    OP_LSH = 4'h6,
    OP_RSH = 4'h7,
    OP_NEG = 4'h8,
    OP_MOD = 4'h9,
    OP_XOR = 4'hA
  } bpf_op_e;

  typedef struct packed {
    logic is_alu;
    logic is_tax;
    logic is_txa;
    logic bad;
  } bpf_dec_t;

  // MUL/DIV/MOD and the undefined ops 0xB-0xF are issued but flag an error.
  function automatic logic op_is_err(input logic [3:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_LSH, OP_RSH, OP_NEG, OP_XOR: r = 1'b0;
      default:                                                       r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic bpf_dec_t bpf_decode(input logic [7:0] code);
    bpf_dec_t d;
    d.is_alu = (code[2:0] == CLS_ALU);
    d.is_tax = (code == CODE_TAX);
    d.is_txa = (code == CODE_TXA);
    if (d.is_alu) begin
      d.bad = op_is_err(code[7:4]);
    end else begin
      d.bad = ~(d.is_tax | d.is_txa);
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_ctl.sv
// Issue/writeback controller for the two-stage pipelined BPF ALU.
// Owns A and X, tracks in-flight ALU ops in a valid shadow, stalls on the RAW hazard on A.
module alu_issue_ctl
  import bpf_isa_pkg::*;
#(
  parameter bit FORWARD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_code,
  input  logic [31:0] in_k,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  output logic [31:0] a_reg,
  output logic [31:0] x_reg,
  output logic        wb_valid,
  output logic        err
);

  logic        v1_r;
  logic        v2_r;
  logic [3:0]  sel_r;
  logic [31:0] a_r;
  logic [31:0] x_r;
  logic        err_r;

  bpf_dec_t    dec_s;
  logic        ready_s;
  logic        accept_s;
  logic        issue_alu_s;
  logic [31:0] a_src_s;
  logic [31:0] b_s;

  // Decode, hazard stall, operand selection.
  always_comb begin
    dec_s = bpf_decode(in_code);
    // Every op but TXA reads A, so all issue is gated while A is not yet available.
    if (FORWARD != 1'b0) begin
      ready_s = ~v1_r;
    end else begin
      ready_s = ~(v1_r | v2_r);
    end
    accept_s    = in_valid & ready_s;
    issue_alu_s = accept_s & dec_s.is_alu;
    if ((FORWARD != 1'b0) && v2_r) begin
      a_src_s = alu_out;
    end else begin
      a_src_s = a_r;
    end
    if (in_code[7:4] == OP_NEG) begin
      b_s = 32'h0000_0000;
    end else if (in_code[SRC_BIT]) begin
      b_s = x_r;
    end else begin
      b_s = in_k;
    end
  end

  // Shadow valids, select register, A/X writeback and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r  <= 1'b0;
      v2_r  <= 1'b0;
      sel_r <= 4'h0;
      a_r   <= 32'h0000_0000;
      x_r   <= 32'h0000_0000;
      err_r <= 1'b0;
    end else begin
      v1_r  <= issue_alu_s;
      v2_r  <= v1_r;
      sel_r <= issue_alu_s ? in_code[7:4] : 4'h0;
      // TXA is younger than any op in s2, so it wins the A write.
      if (accept_s && dec_s.is_txa) begin
        a_r <= x_r;
      end else if (v2_r) begin
        a_r <= alu_out;
      end
      if (accept_s && dec_s.is_tax) begin
        x_r <= a_src_s;
      end
      if (accept_s && dec_s.bad) begin
        err_r <= 1'b1;
      end
    end
  end

  assign in_ready = ready_s;
  assign alu_A    = a_src_s;
  assign alu_B    = b_s;
  assign alu_sel  = sel_r;
  assign a_reg    = a_r;
  assign x_reg    = x_r;
  assign wb_valid = v2_r;
  assign err      = err_r;

endmodule

// File: tb/tb_alu_issue_ctl.sv
// Table-driven bench: one instance with forwarding, one without, each with a behavioural 2-stage ALU.
module tb_alu_issue_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst;
  logic [1:0]        in_valid;
  logic [1:0]        in_ready;
  logic [1:0][7:0]   in_code;
  logic [1:0][31:0]  in_k;
  logic [1:0][31:0]  alu_A;
  logic [1:0][31:0]  alu_B;
  logic [1:0][3:0]   alu_sel;
  logic [1:0][31:0]  alu_out;
  logic [1:0][31:0]  a_reg;
  logic [1:0][31:0]  x_reg;
  logic [1:0]        wb_valid;
  logic [1:0]        err;

  alu_issue_ctl #(.FORWARD(1'b0)) dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_code(in_code[0]), .in_k(in_k[0]), .alu_A(alu_A[0]), .alu_B(alu_B[0]),
    .alu_sel(alu_sel[0]), .alu_out(alu_out[0]), .a_reg(a_reg[0]), .x_reg(x_reg[0]),
    .wb_valid(wb_valid[0]), .err(err[0])
  );

  alu_issue_ctl #(.FORWARD(1'b1)) dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_code(in_code[1]), .in_k(in_k[1]), .alu_A(alu_A[1]), .alu_B(alu_B[1]),
    .alu_sel(alu_sel[1]), .alu_out(alu_out[1]), .a_reg(a_reg[1]), .x_reg(x_reg[1]),
    .wb_valid(wb_valid[1]), .err(err[1])
  );

  function automatic logic [31:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (s)
      4'h0:             r = a + b;
      4'h1:             r = a - b;
      4'h2, 4'h3, 4'h9: r = 32'hDEAD_BEEF;
      4'h4:             r = a | b;
      4'h5:             r = a & b;
      4'h6:             r = a << b[4:0];
      4'h7:             r = a >> b[4:0];
      4'h8:             r = 32'h0000_0000 - a;
      4'hA:             r = a ^ b;
      default:          r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // ALU model: operands sampled in the accept cycle, select one cycle later, result in s2.
  logic [1:0][31:0] opa_q, opb_q, res_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      opa_q[i] <= alu_A[i];
      opb_q[i] <= alu_B[i];
      res_q[i] <= alu_f(alu_sel[i], opa_q[i], opb_q[i]);
    end
  end
  assign alu_out = res_q;

  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  code;
    logic [31:0] k;
    logic        rdy;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] a;
    logic [31:0] x;
    logic        wb;
    logic        err;
    logic [3:0]  sel;
  } vec_t;

  function automatic vec_t mv(input logic r, input logic v, input logic [7:0] code, input logic [31:0] k,
                              input logic rdy, input logic [31:0] ea, input logic [31:0] eb,
                              input logic [31:0] a, input logic [31:0] x, input logic wb,
                              input logic e, input logic [3:0] sel);
    vec_t t;
    t.r = r; t.v = v; t.code = code; t.k = k; t.rdy = rdy; t.ea = ea; t.eb = eb;
    t.a = a; t.x = x; t.wb = wb; t.err = e; t.sel = sel;
    return t;
  endfunction

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int d, input int idx, input vec_t t);
    rst[d]      = t.r;
    in_valid[d] = t.v;
    in_code[d]  = t.code;
    in_k[d]     = t.k;
    #1;
    chk($sformatf("d%0d v%0d in_ready", d, idx), {31'd0, in_ready[d]}, {31'd0, t.rdy});
    chk($sformatf("d%0d v%0d a_reg", d, idx), a_reg[d], t.a);
    chk($sformatf("d%0d v%0d x_reg", d, idx), x_reg[d], t.x);
    chk($sformatf("d%0d v%0d wb_valid", d, idx), {31'd0, wb_valid[d]}, {31'd0, t.wb});
    chk($sformatf("d%0d v%0d err", d, idx), {31'd0, err[d]}, {31'd0, t.err});
    chk($sformatf("d%0d v%0d alu_sel", d, idx), {28'd0, alu_sel[d]}, {28'd0, t.sel});
    if (t.v) begin
      chk($sformatf("d%0d v%0d alu_A", d, idx), alu_A[d], t.ea);
      chk($sformatf("d%0d v%0d alu_B", d, idx), alu_B[d], t.eb);
    end
    @(posedge clk);
    #1;
    rst[d]      = 1'b0;
    in_valid[d] = 1'b0;
  endtask

  vec_t t0[7];
  vec_t t1[37];

  initial begin
    // No forwarding: ADD K=5 then SUB X held valid, two stall cycles.
    t0[0] = mv(0, 1, 8'h04, 32'h5, 1, 32'h0, 32'h5, 32'h0, 32'h0, 0, 0, 4'h0);
    t0[1] = mv(0, 1, 8'h1C, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 4'h0);
    t0[2] = mv(0, 1, 8'h1C, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 4'h0);
    t0[3] = mv(0, 1, 8'h1C, 32'h0, 1, 32'h5, 32'h0, 32'h5, 32'h0, 0, 0, 4'h0);
    t0[4] = mv(0, 0, 8'h00, 32'h0, 0, 32'h0, 32'h0, 32'h5, 32'h0, 0, 0, 4'h1);
    t0[5] = mv(0, 0, 8'h00, 32'h0, 0, 32'h0, 32'h0, 32'h5, 32'h0, 1, 0, 4'h0);
    t0[6] = mv(0, 0, 8'h00, 32'h0, 1, 32'h0, 32'h0, 32'h5, 32'h0, 0, 0, 4'h0);

    // Forwarding: ADD/SUB, AND/OR/TAX/OR/TXA override, DIV error, LD, resets mid-flight.
    t1[0]  = mv(0, 1, 8'h04, 32'h5,  1, 32'h0,  32'h5,  32'h0, 32'h0, 0, 0, 4'h0);
    t1[1]  = mv(0, 1, 8'h1C, 32'h0,  0, 32'h0,  32'h0,  32'h0, 32'h0, 0, 0, 4'h0);
    t1[2]  = mv(0, 1, 8'h1C, 32'h0,  1, 32'h5,  32'h0,  32'h0, 32'h0, 1, 0, 4'h0);
    t1[3]  = mv(0, 0, 8'h00, 32'h0,  0, 32'h0,  32'h0,  32'h5, 32'h0, 0, 0, 4'h1);
    t1[4]  = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'h5, 32'h0, 1, 0, 4'h0);
    t1[5]  = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'h5, 32'h0, 0, 0, 4'h0);
    t1[6]  = mv(0, 1, 8'h54, 32'h0,  1, 32'h5,  32'h0,  32'h5, 32'h0, 0, 0, 4'h0);
    t1[7]  = mv(0, 1, 8'h44, 32'hF0, 0, 32'h5,  32'hF0, 32'h5, 32'h0, 0, 0, 4'h5);
    t1[8]  = mv(0, 1, 8'h44, 32'hF0, 1, 32'h0,  32'hF0, 32'h5, 32'h0, 1, 0, 4'h0);
    t1[9]  = mv(0, 1, 8'h07, 32'h0,  0, 32'h0,  32'h0,  32'h0, 32'h0, 0, 0, 4'h4);
    t1[10] = mv(0, 1, 8'h07, 32'h0,  1, 32'hF0, 32'h0,  32'h0, 32'h0, 1, 0, 4'h0);
    t1[11] = mv(0, 1, 8'h44, 32'h0F, 1, 32'hF0, 32'h0F, 32'hF0, 32'hF0, 0, 0, 4'h0);
    t1[12] = mv(0, 1, 8'h87, 32'h0,  0, 32'hF0, 32'h0,  32'hF0, 32'hF0, 0, 0, 4'h4);
    t1[13] = mv(0, 1, 8'h87, 32'h0,  1, 32'hFF, 32'h0,  32'hF0, 32'hF0, 1, 0, 4'h0);
    t1[14] = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'hF0, 32'hF0, 0, 0, 4'h0);
    t1[15] = mv(0, 1, 8'h34, 32'h3,  1, 32'hF0, 32'h3,  32'hF0, 32'hF0, 0, 0, 4'h0);
    t1[16] = mv(0, 0, 8'h00, 32'h0,  0, 32'h0,  32'h0,  32'hF0, 32'hF0, 0, 1, 4'h3);
    t1[17] = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'hF0, 32'hF0, 1, 1, 4'h0);
    t1[18] = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'hDEADBEEF, 32'hF0, 0, 1, 4'h0);
    t1[19] = mv(0, 1, 8'h04, 32'h1,  1, 32'hDEADBEEF, 32'h1, 32'hDEADBEEF, 32'hF0, 0, 1, 4'h0);
    t1[20] = mv(0, 0, 8'h00, 32'h0,  0, 32'h0,  32'h0,  32'hDEADBEEF, 32'hF0, 0, 1, 4'h0);
    t1[21] = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'hDEADBEEF, 32'hF0, 1, 1, 4'h0);
    t1[22] = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'hDEADBEF0, 32'hF0, 0, 1, 4'h0);
    t1[23] = mv(1, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'hDEADBEF0, 32'hF0, 0, 1, 4'h0);
    t1[24] = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'h0, 32'h0, 0, 0, 4'h0);
    t1[25] = mv(0, 1, 8'h00, 32'h1234, 1, 32'h0, 32'h1234, 32'h0, 32'h0, 0, 0, 4'h0);
    t1[26] = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'h0, 32'h0, 0, 1, 4'h0);
    t1[27] = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'h0, 32'h0, 0, 1, 4'h0);
    t1[28] = mv(1, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'h0, 32'h0, 0, 1, 4'h0);
    t1[29] = mv(0, 1, 8'h04, 32'h7,  1, 32'h0,  32'h7,  32'h0, 32'h0, 0, 0, 4'h0);
    t1[30] = mv(1, 0, 8'h00, 32'h0,  0, 32'h0,  32'h0,  32'h0, 32'h0, 0, 0, 4'h0);
    t1[31] = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'h0, 32'h0, 0, 0, 4'h0);
    t1[32] = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'h0, 32'h0, 0, 0, 4'h0);
    t1[33] = mv(0, 1, 8'h44, 32'h7,  1, 32'h0,  32'h7,  32'h0, 32'h0, 0, 0, 4'h0);
    t1[34] = mv(1, 0, 8'h00, 32'h0,  0, 32'h0,  32'h0,  32'h0, 32'h0, 0, 0, 4'h4);
    t1[35] = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'h0, 32'h0, 0, 0, 4'h0);
    t1[36] = mv(0, 0, 8'h00, 32'h0,  1, 32'h0,  32'h0,  32'h0, 32'h0, 0, 0, 4'h0);

    rst      = 2'b11;
    in_valid = 2'b00;
    in_code  = '0;
    in_k     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 2'b00;

    for (int i = 0; i < 7; i++) begin
      run_vec(0, i, t0[i]);
    end
    for (int i = 0; i < 37; i++) begin
      run_vec(1, i, t1[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctl.md
# alu_issue_ctl

Issue and writeback controller that sits directly upstream of the two-stage pipelined ALU in the packet-filter datapath. It accepts decoded classic-BPF ALU/MISC instructions over a valid/ready handshake and owns the accumulator A and index X registers. It drives the ALU operands in the accept cycle and the ALU select one cycle later, matching the ALU's skewed schedule. It writes the ALU result back into A and stalls on the read-after-write hazard on A.

## Interface
- FORWARD, 1: when 1, forward `alu_out` into the A operand and stall one cycle between dependent ops; when 0, read A from `a_reg` only and stall two cycles.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  block can accept this cycle
- in_code  in  8  BPF opcode byte: [2:0] class, [3] source (0=K, 1=X), [7:4] op
- in_k  in  32  immediate K
- alu_A  out  32  ALU operand A, valid in the accept cycle
- alu_B  out  32  ALU operand B, valid in the accept cycle
- alu_sel  out  4  ALU select, valid in the cycle after accept
- alu_out  in  32  ALU result, valid two cycles after accept
- a_reg  out  32  accumulator A
- x_reg  out  32  index register X
- wb_valid  out  1  high in the cycle whose closing edge writes `alu_out` into A
- err  out  1  sticky: unsupported or unknown instruction seen

## Operation
- Accept occurs when `in_valid & in_ready`.
- ALU class (`in_code[2:0]=3'b100`) uses a 3-stage valid shadow: s0 = accept cycle, s1, s2.
  - `alu_A` is the A source.
  - `alu_B` is `x_reg` when bit 3 is 1, otherwise `in_k`. It is forced to 0 for op 8.
  - `in_code[7:4]` is registered and presented on `alu_sel` in s1.
  - In s2, `wb_valid`=1 and A <= `alu_out` at the closing edge.
- A source:
  - FORWARD=1: `alu_out` when an ALU op is in s2 this cycle, else `a_reg`.
  - FORWARD=0: always `a_reg`.
- MISC class (`in_code[2:0]=3'b111`):
  - TAX (`in_code`=8'h07): X <= A source at the accept edge.
  - TXA (8'h87): A <= X at the accept edge.
  - Neither uses the ALU.
- Ops 2 (MUL), 3 (DIV) and 9 (MOD) are issued normally; A receives the ALU's error constant and `err` is set. The same applies to ops 0xB-0xF, which return 0.
- Any other class or MISC code is accepted and dropped with no state change, and `err` is set.
- `err` clears only on `rst`.

## Timing
- Reset values: `a_reg`=0, `x_reg`=0, `alu_sel`=0, `wb_valid`=0, `err`=0, all shadow valids=0. `in_ready`=1 in the cycle after reset deasserts.
- `alu_A`/`alu_B` are combinational from the current inputs and state. `in_ready` is combinational from state only, never from `in_valid`.
- Hazard rule (every accepted instruction except TXA reads A):
  - FORWARD=1: `in_ready`=0 while an ALU op is in s1, so the minimum spacing is 2 cycles (accept t, next t+2 using forwarded `alu_out`).
  - FORWARD=0: `in_ready`=0 while an ALU op is in s1 or s2; the minimum spacing is 3 cycles.
  - TXA is gated by the same rule, for uniformity.
- Non-ALU instructions do not occupy the shadow pipeline, so MISC ops may issue back-to-back.
- Simultaneous writes to A at one edge (TXA accepted while an ALU op is in s2): TXA wins, being the younger instruction. `wb_valid` still pulses.
- `rst` mid-flight clears all shadow valids: no writeback, and `alu_sel` is 0 on the next cycle.

## Structure
- Shared package `bpf_isa_pkg`:
  - class constants: ALU=3'b100, MISC=3'b111
  - op codes 0x0-0xA
  - source-bit index
  - TAX/TXA codes
- Shared with the jump unit and the datapath.
- No sub-module. The hazard/shadow logic is about 40 lines and stays inline.
- The datapath instantiates this block beside the pipelined ALU and wires `alu_*` directly.

## Test plan
- Reset, then ADD K (8'h04, k=5), then SUB X (8'h1C, X=0): `alu_sel`=0 one cycle after accept; `a_reg`=5 three cycles after accept; the SUB is accepted 2 cycles after the ADD (FORWARD=1) with `alu_A`=5 forwarded; final `a_reg`=5.
- FORWARD=0, same two ops with `in_valid` held high: `in_ready` is low for 2 cycles, and the SUB's `alu_A` comes from `a_reg`=5.
- A=0xF0, TAX, then OR K (8'h44, k=0x0F), then TXA in the forwarding slot: X=0xF0; A=0xF0 (TXA overrides the OR writeback 0xFF); `wb_valid` still pulses.
- DIV K (8'h34): A=32'hDEADBEEF after 3 cycles; `err`=1 and stays 1 through later legal ops until `rst`.
- Unknown class (8'h00, LD): accepted in one cycle, no change to A/X, `err`=1, no `wb_valid`.
- Assert `rst` in the s1 cycle of an ADD K=7: `a_reg` stays 0, `wb_valid` never pulses, `in_ready`=1 one cycle after reset deasserts.
